// File: rtl/adc_gpio_bridge_if.sv
// SoC GPIO command/response pair plus the ADC128S022-style SPI pins.
// The bridge owns the slave side; the SoC/board side drives the master side.
interface adc_gpio_bridge_if;
    logic [9:0] gpio_cmd;
    logic [9:0] gpio_rsp;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic       adc_din;
    logic       adc_dout;

    modport slave (
        input  gpio_cmd,
        input  adc_dout,
        output gpio_rsp,
        output adc_cs_n,
        output adc_sclk,
        output adc_din
    );

    modport master (
        output gpio_cmd,
        output adc_dout,
        input  gpio_rsp,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_din
    );
endinterface

// File: rtl/adc_gpio_bridge.sv
// GPIO-commanded ADC128S022 SPI reader with a 4-phase req/ack handshake.
// SPI pins are registered so SCLK/CS_N never glitch.
module adc_gpio_bridge #(
    parameter int unsigned CLK_DIV    = 25,
    parameter bit          DUAL_FRAME = 1'b1
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    adc_gpio_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE, WAIT_REL
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [7:0]  hcnt, hcnt_n;
    logic [3:0]  bcnt, bcnt_n;
    logic        hi, hi_n;
    logic        second, second_n;
    logic [2:0]  chan, chan_n;
    logic [11:0] rx, rx_n;
    logic [11:0] result, result_n;
    logic        ack, ack_n;
    logic        busy, busy_n;
    logic        cs_n, cs_n_n;
    logic        sclk, sclk_n;
    logic        din, din_n;

    logic        req;
    logic        half_end;
    logic [15:0] frame;
    logic [3:0]  bit_nx;
    logic        din_nx;
    logic [7:0]  data;
    logic        unused_cmd;

    assign req        = bus.gpio_cmd[9];
    assign half_end   = (hcnt == HALF_LAST);
    assign frame      = {2'b00, chan, 11'b0};
    assign bit_nx     = bcnt + 4'd1;
    assign din_nx     = frame[4'd15 - bit_nx];
    assign unused_cmd = ^bus.gpio_cmd[7:3];

    always_comb begin
        state_n  = state;
        hcnt_n   = hcnt;
        bcnt_n   = bcnt;
        hi_n     = hi;
        second_n = second;
        chan_n   = chan;
        rx_n     = rx;
        result_n = result;
        ack_n    = ack;
        busy_n   = busy;
        cs_n_n   = 1'b1;
        sclk_n   = 1'b1;
        din_n    = din;
        unique case (state)
            IDLE: begin
                din_n = 1'b0;
                // Request is latched first; the frame starts one edge later.
                if (busy) begin
                    state_n = CS_SETUP;
                    hcnt_n  = 8'd0;
                    cs_n_n  = 1'b0;
                    din_n   = frame[15];
                end else if (req) begin
                    busy_n = 1'b1;
                    chan_n = bus.gpio_cmd[2:0];
                end
            end
            CS_SETUP: begin
                cs_n_n = 1'b0;
                if (half_end) begin
                    state_n = SHIFT;
                    hcnt_n  = 8'd0;
                    bcnt_n  = 4'd0;
                    hi_n    = 1'b0;
                    sclk_n  = 1'b0;
                end else begin
                    hcnt_n = hcnt + 8'd1;
                end
            end
            SHIFT: begin
                cs_n_n = 1'b0;
                sclk_n = hi;
                if (!half_end) begin
                    hcnt_n = hcnt + 8'd1;
                end else begin
                    hcnt_n = 8'd0;
                    if (!hi) begin
                        // Last cycle of the low half: SCLK rises here.
                        hi_n   = 1'b1;
                        sclk_n = 1'b1;
                        rx_n   = {rx[10:0], bus.adc_dout};
                    end else if (bcnt == 4'd15) begin
                        state_n = CS_HOLD;
                        bcnt_n  = 4'd0;
                        hi_n    = 1'b0;
                        cs_n_n  = 1'b1;
                    end else begin
                        bcnt_n = bit_nx;
                        hi_n   = 1'b0;
                        sclk_n = 1'b0;
                        din_n  = din_nx;
                    end
                end
            end
            CS_HOLD: begin
                if (half_end) begin
                    hcnt_n = 8'd0;
                    if (DUAL_FRAME && !second) begin
                        state_n  = CS_SETUP;
                        second_n = 1'b1;
                        cs_n_n   = 1'b0;
                        din_n    = frame[15];
                    end else begin
                        state_n  = DONE;
                        second_n = 1'b0;
                    end
                end else begin
                    hcnt_n = hcnt + 8'd1;
                end
            end
            DONE: begin
                din_n    = 1'b0;
                result_n = rx;
                busy_n   = 1'b0;
                if (req) begin
                    ack_n   = 1'b1;
                    state_n = WAIT_REL;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT_REL: begin
                if (!req) begin
                    ack_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state  <= IDLE;
            hcnt   <= 8'd0;
            bcnt   <= 4'd0;
            hi     <= 1'b0;
            second <= 1'b0;
            chan   <= 3'd0;
            rx     <= 12'h000;
            result <= 12'h000;
            ack    <= 1'b0;
            busy   <= 1'b0;
            cs_n   <= 1'b1;
            sclk   <= 1'b1;
            din    <= 1'b0;
        end else begin
            state  <= state_n;
            hcnt   <= hcnt_n;
            bcnt   <= bcnt_n;
            hi     <= hi_n;
            second <= second_n;
            chan   <= chan_n;
            rx     <= rx_n;
            result <= result_n;
            ack    <= ack_n;
            busy   <= busy_n;
            cs_n   <= cs_n_n;
            sclk   <= sclk_n;
            din    <= din_n;
        end
    end

    assign data = bus.gpio_cmd[8] ? {4'b0000, result[11:8]} : result[7:0];

    assign bus.gpio_rsp = {ack, busy, data};
    assign bus.adc_cs_n = cs_n;
    assign bus.adc_sclk = sclk;
    assign bus.adc_din  = din;

endmodule
